// File: rtl/debug_dump_ctrl_pkg.sv
// Shared types and constants for the debug dump controller.
// Latency: n/a (types, constants, pure function).
// Backpressure: n/a.
package debug_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SEND,
        ST_NEXT,
        ST_FINISH
    } dump_state_t;

    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    // 'A' - 10 = 8'h37, so letters come out upper case.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/debug_line_fmt.sv
// Selects one ASCII byte of the line "AA:DDDDDDDD\r\n" by byte index.
// Latency: combinational.
// Backpressure: none; the caller holds the index while stalled.
module debug_line_fmt
    import debug_dump_ctrl_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [31:0]       cap_data,
    input  logic [3:0]        byte_idx,
    output logic [7:0]        line_byte
);

    logic [7:0] addr8;

    assign addr8 = 8'(cap_addr);

    always_comb begin
        line_byte = 8'h00;
        case (byte_idx)
            4'd0:  line_byte = nib2ascii(addr8[7:4]);
            4'd1:  line_byte = nib2ascii(addr8[3:0]);
            4'd2:  line_byte = COLON;
            4'd3:  line_byte = nib2ascii(cap_data[31:28]);
            4'd4:  line_byte = nib2ascii(cap_data[27:24]);
            4'd5:  line_byte = nib2ascii(cap_data[23:20]);
            4'd6:  line_byte = nib2ascii(cap_data[19:16]);
            4'd7:  line_byte = nib2ascii(cap_data[15:12]);
            4'd8:  line_byte = nib2ascii(cap_data[11:8]);
            4'd9:  line_byte = nib2ascii(cap_data[7:4]);
            4'd10: line_byte = nib2ascii(cap_data[3:0]);
            4'd11: line_byte = CR;
            4'd12: line_byte = LF;
            default: line_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/debug_dump_ctrl.sv
// Sweeps the CPU debug port and streams each entry as an ASCII hex line to the UART.
// Latency: first byte valid SETTLE+1 clocks after start is sampled; 1 byte per 2 clocks.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; the sweep pauses with them.
module debug_dump_ctrl
    import debug_dump_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int NUM_ENTRIES = 128,
    parameter int SETTLE      = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] debug_addr,
    input  logic [DATA_W-1:0] debug_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_ENTRIES - 1);
    localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE - 1);

    dump_state_t       state, state_nxt;
    logic [3:0]        settle_cnt;
    logic [3:0]        byte_idx;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;
    logic [ADDR_W-1:0] fmt_addr;
    logic [DATA_W-1:0] fmt_data;
    logic [7:0]        fmt_byte;
    logic              tx_accept;
    logic              last_byte;
    logic              last_entry;

    assign tx_accept  = tx_valid && tx_ready;
    assign last_byte  = (byte_idx == 4'd12);
    assign last_entry = (debug_addr == LAST_ADDR);

    // The first byte is loaded in the same edge that captures, so format from the live port then.
    assign fmt_addr = (state == ST_CAPTURE) ? debug_addr : cap_addr;
    assign fmt_data = (state == ST_CAPTURE) ? debug_data : cap_data;

    debug_line_fmt #(
        .ADDR_W (ADDR_W)
    ) u_line_fmt (
        .cap_addr  (fmt_addr),
        .cap_data  (fmt_data),
        .byte_idx  (byte_idx),
        .line_byte (fmt_byte)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_SETTLE;
            ST_SETTLE:  if (settle_cnt == 4'd0) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_SEND;
            ST_SEND:    if (tx_accept && last_byte) state_nxt = ST_NEXT;
            ST_NEXT:    state_nxt = last_entry ? ST_FINISH : ST_SETTLE;
            ST_FINISH:  state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            debug_addr <= '0;
            settle_cnt <= '0;
            byte_idx   <= '0;
            cap_addr   <= '0;
            cap_data   <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        debug_addr <= '0;
                        busy       <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                ST_CAPTURE: begin
                    cap_addr <= debug_addr;
                    cap_data <= debug_data;
                    tx_data  <= fmt_byte;
                    tx_valid <= 1'b1;
                end
                ST_SEND: begin
                    // A one-cycle gap after every acceptance keeps tx_valid purely registered.
                    if (tx_accept) begin
                        tx_valid <= 1'b0;
                        byte_idx <= last_byte ? 4'd0 : byte_idx + 4'd1;
                    end else if (!tx_valid) begin
                        tx_data  <= fmt_byte;
                        tx_valid <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (last_entry) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        debug_addr <= '0;
                    end else begin
                        debug_addr <= debug_addr + ADDR_W'(1);
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Directed bench: a 2-entry/SETTLE=3 instance with an X-until-settled data model,
// and a full 128-entry instance for long dump, start-while-busy and mid-line reset.
module tb_debug_dump_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // small instance: NUM_ENTRIES=2, SETTLE=3
    logic        s_start, s_rdy, s_txv, s_busy, s_done;
    logic [6:0]  s_addr;
    logic [31:0] s_data;
    logic [7:0]  s_txd;

    // full instance: defaults (128 entries, SETTLE=2)
    logic        f_start, f_rdy, f_txv, f_busy, f_done;
    logic [6:0]  f_addr;
    logic [31:0] f_data;
    logic [7:0]  f_txd;

    int n_vec = 0;
    int n_err = 0;

    debug_dump_ctrl #(.ADDR_W(7), .DATA_W(32), .NUM_ENTRIES(2), .SETTLE(3)) u_small (
        .clock(clk), .reset(rst), .start(s_start), .debug_addr(s_addr), .debug_data(s_data),
        .tx_data(s_txd), .tx_valid(s_txv), .tx_ready(s_rdy), .busy(s_busy), .done(s_done)
    );

    debug_dump_ctrl u_full (
        .clock(clk), .reset(rst), .start(f_start), .debug_addr(f_addr), .debug_data(f_data),
        .tx_data(f_txd), .tx_valid(f_txv), .tx_ready(f_rdy), .busy(f_busy), .done(f_done)
    );

    // Small data model: X until the address has been stable for 3 full clocks.
    int         s_age = 100;
    int         s_mode = 0;
    logic [6:0] s_addr_last = '0;
    always @(negedge clk) begin
        if (s_addr !== s_addr_last) begin
            s_addr_last = s_addr;
            s_age = 0;
        end else if (s_age < 100) begin
            s_age = s_age + 1;
        end
    end
    assign s_data = (s_age < 3) ? 32'hxxxx_xxxx :
                    (s_mode == 1) ? 32'h0123_ABCF :
                    (s_addr != 7'd0) ? 32'hDEAD_BEEF : 32'h0000_000A;

    assign f_data = {1'b0, f_addr, 1'b0, f_addr, 1'b0, f_addr, 1'b0, f_addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'(48 + int'(n)) : 8'(55 + int'(n));
    endfunction

    // Expected byte idx of the full dump for f_data's pattern.
    function automatic logic [7:0] f_exp(input int idx);
        logic [6:0]  la;
        logic [7:0]  a8;
        logic [31:0] d;
        int          k;
        la = 7'(idx / 13);
        k  = idx % 13;
        a8 = {1'b0, la};
        d  = {1'b0, la, 1'b0, la, 1'b0, la, 1'b0, la};
        case (k)
            0:  return hexc(a8[7:4]);
            1:  return hexc(a8[3:0]);
            2:  return 8'h3A;
            11: return 8'h0D;
            12: return 8'h0A;
            default: return hexc(d[31 - 4*(k-3) -: 4]);
        endcase
    endfunction

    task automatic pulse_s();
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
    endtask

    task automatic pulse_f();
        @(negedge clk); f_start = 1'b1;
        @(negedge clk); f_start = 1'b0;
    endtask

    // Runs one dump on the small instance; bp=1 gives ready 3 low / 1 high.
    task automatic run_small(input string tag, input string exp, input int bp);
        int         nb = 0;
        int         ndone = 0;
        int         lat = -1;
        logic       hold = 1'b0;
        logic [7:0] hold_d = '0;
        logic       rdy;
        pulse_s();
        chk({tag, " busy_after_start"}, 32'(s_busy), 32'd1);
        for (int c = 0; c < 3000; c++) begin
            if (s_txv && lat < 0) lat = c;
            if (hold) begin
                chk({tag, " hold_valid"}, 32'(s_txv), 32'd1);
                chk({tag, " hold_data"}, 32'(s_txd), 32'(hold_d));
            end
            rdy = (bp != 0) ? ((c % 4) == 3) : 1'b1;
            s_rdy = rdy;
            if (s_txv && rdy) begin
                if (nb < exp.len())
                    chk($sformatf("%s byte%0d", tag, nb), 32'(s_txd), 32'(exp[nb]));
                nb++;
            end
            hold   = s_txv && !rdy;
            hold_d = s_txd;
            if (s_done) begin
                ndone++;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " done_seen"}, 32'(ndone), 32'd1);
        chk({tag, " byte_count"}, 32'(nb), 32'(exp.len()));
        if (bp == 0) chk({tag, " first_byte_latency"}, 32'(lat), 32'd4);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(s_done), 32'd0);
        chk({tag, " busy_after_done"}, 32'(s_busy), 32'd0);
    endtask

    initial begin
        int         nb;
        int         ndone;
        int         bad;
        int         hit;
        logic       again;
        logic [7:0] l7f_0, l7f_1;

        rst = 1'b1; s_start = 1'b0; f_start = 1'b0; s_rdy = 1'b0; f_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst s_addr", 32'(s_addr), 32'd0);
        chk("rst s_txd", 32'(s_txd), 32'd0);
        chk("rst s_txv", 32'(s_txv), 32'd0);
        chk("rst s_busy", 32'(s_busy), 32'd0);
        chk("rst s_done", 32'(s_done), 32'd0);
        chk("rst f_txv", 32'(f_txv), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1 + 3: two lines, full ready, addr 1 data X until settled
        s_mode = 0;
        run_small("t1", "00:0000000A\r\n01:DEADBEEF\r\n", 0);
        // 2: backpressure
        run_small("t2", "00:0000000A\r\n01:DEADBEEF\r\n", 1);
        // 6: nibble coverage, upper-case letters
        s_mode = 1;
        run_small("t6", "00:0123ABCF\r\n01:0123ABCF\r\n", 0);

        // 4: full dump, start re-pulsed on the 5th byte
        f_rdy = 1'b1;
        pulse_f();
        nb = 0; ndone = 0; bad = 0; again = 1'b0; l7f_0 = '0; l7f_1 = '0;
        for (int c = 0; c < 8000; c++) begin
            f_start = 1'b0;
            if (f_txv && nb == 4 && !again) begin
                f_start = 1'b1;
                again   = 1'b1;
            end
            if (f_done) begin
                ndone++;
                break;
            end
            if (!f_busy) bad++;
            if (f_txv && f_rdy) begin
                chk($sformatf("t4 byte%0d", nb), 32'(f_txd), 32'(f_exp(nb)));
                if (nb == 127*13)     l7f_0 = f_txd;
                if (nb == 127*13 + 1) l7f_1 = f_txd;
                nb++;
            end
            @(negedge clk);
        end
        f_start = 1'b0;
        chk("t4 restart_pulsed", 32'(again), 32'd1);
        chk("t4 done_seen", 32'(ndone), 32'd1);
        chk("t4 byte_count", 32'(nb), 32'd1664);
        chk("t4 busy_gaps", 32'(bad), 32'd0);
        chk("t4 last_line_hi", 32'(l7f_0), 32'h37);
        chk("t4 last_line_lo", 32'(l7f_1), 32'h46);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (f_txv || f_busy || f_done) bad++;
        end
        chk("t4 no_second_dump", 32'(bad), 32'd0);

        // 5: reset at byte 6 of address 0x10
        pulse_f();
        nb = 0; hit = 0;
        for (int c = 0; c < 6000; c++) begin
            if (f_txv && nb == 16*13 + 6) begin
                chk("t5 addr_at_cut", 32'(f_addr), 32'h10);
                rst = 1'b1;
                #1;
                chk("t5 txv_in_reset", 32'(f_txv), 32'd0);
                chk("t5 busy_in_reset", 32'(f_busy), 32'd0);
                chk("t5 addr_in_reset", 32'(f_addr), 32'd0);
                hit = 1;
                break;
            end
            if (f_txv && f_rdy) nb++;
            @(negedge clk);
        end
        chk("t5 reached_cut", 32'(hit), 32'd1);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        pulse_f();
        nb = 0;
        for (int c = 0; c < 200 && nb < 13; c++) begin
            if (f_txv && f_rdy) begin
                chk($sformatf("t5 redump byte%0d", nb), 32'(f_txd), 32'(f_exp(nb)));
                nb++;
            end
            @(negedge clk);
        end
        chk("t5 redump_count", 32'(nb), 32'd13);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
